// File: rtl/tx_data_gen_pkg.sv
// Shared types and polynomial constants for the tx_data_gen pattern source.
// Mode decode, tap table and width masks for PRBS7/9/15/31.
package tx_data_gen_pkg;

  typedef enum logic [2:0] {
    GEN_FIXED  = 3'd0,
    GEN_PRBS7  = 3'd1,
    GEN_PRBS9  = 3'd2,
    GEN_PRBS15 = 3'd3,
    GEN_PRBS31 = 3'd4
  } tx_gen_mode_t;

  localparam int PRBS7_P  = 7;
  localparam int PRBS7_Q  = 6;
  localparam int PRBS9_P  = 9;
  localparam int PRBS9_Q  = 5;
  localparam int PRBS15_P = 15;
  localparam int PRBS15_Q = 14;
  localparam int PRBS31_P = 31;
  localparam int PRBS31_Q = 28;

  function automatic tx_gen_mode_t gen_mode(logic [2:0] m);
    case (m)
      3'd1:    return GEN_PRBS7;
      3'd2:    return GEN_PRBS9;
      3'd3:    return GEN_PRBS15;
      3'd4:    return GEN_PRBS31;
      default: return GEN_FIXED;
    endcase
  endfunction

  // FIXED keeps the full register visible
  function automatic logic [63:0] poly_mask(tx_gen_mode_t m);
    case (m)
      GEN_PRBS7:  return (64'd1 << PRBS7_P) - 64'd1;
      GEN_PRBS9:  return (64'd1 << PRBS9_P) - 64'd1;
      GEN_PRBS15: return (64'd1 << PRBS15_P) - 64'd1;
      GEN_PRBS31: return (64'd1 << PRBS31_P) - 64'd1;
      default:    return '1;
    endcase
  endfunction

endpackage

// File: rtl/tx_data_gen_lfsr.sv
// tx_lfsr_step16: combinational 16-step Fibonacci LFSR unroll.
// Masks the state to the polynomial width and revives an all-zero state.
module tx_lfsr_step16
  import tx_data_gen_pkg::*;
#(
  parameter int LFSR_W = 32
) (
  input  logic [LFSR_W-1:0] state_i,
  input  tx_gen_mode_t      mode_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [15:0]       word_o
);

  logic [LFSR_W-1:0] mask;
  logic [LFSR_W-1:0] s;
  logic              nb;

  always_comb begin
    mask   = LFSR_W'(poly_mask(mode_i));
    s      = state_i & mask;
    nb     = 1'b0;
    word_o = '0;
    if (s == '0) s = mask;
    for (int k = 0; k < 16; k++) begin
      unique case (mode_i)
        GEN_PRBS7:  nb = s[PRBS7_P-1] ^ s[PRBS7_Q-1];
        GEN_PRBS9:  nb = s[PRBS9_P-1] ^ s[PRBS9_Q-1];
        GEN_PRBS15: nb = s[PRBS15_P-1] ^ s[PRBS15_Q-1];
        GEN_PRBS31: nb = s[PRBS31_P-1] ^ s[PRBS31_Q-1];
        default:    nb = 1'b0;
      endcase
      word_o[k] = nb;
      s = {s[LFSR_W-2:0], nb} & mask;
    end
    state_o = s;
  end

endmodule

// File: rtl/tx_data_gen.sv
// tx_data_gen: word-parallel preamble + PRBS/fixed source for the 16:1 Tx.
// Optional error injection enabled by defining TX_DATA_GEN_ERR_INJ_EN.
module tx_data_gen
  import tx_data_gen_pkg::*;
#(
  parameter int PRE_W  = 8,
  parameter int LFSR_W = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [LFSR_W-1:0] seed,
  input  logic              load_seed,
  input  logic [15:0]       fixed_pat,
  input  logic [15:0]       pre_pat,
  input  logic [PRE_W-1:0]  pre_len,
  input  logic              invert,
`ifdef TX_DATA_GEN_ERR_INJ_EN
  input  logic              err_inj,
  input  logic [3:0]        err_pos,
  output logic [7:0]        err_cnt,
`endif
  output logic [15:0]       dout,
  output logic              dout_valid,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PRE_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]       dout_q, dout_d;
  logic              valid_q, valid_d;

  tx_gen_mode_t      gmode;
  logic              prbs_on;
  logic [LFSR_W-1:0] mask_w;
  logic [LFSR_W-1:0] seed_m;
  logic [LFSR_W-1:0] seed_ld;
  logic [LFSR_W-1:0] step_state;
  logic [15:0]       step_word;
  logic [15:0]       inv_w;

  assign gmode   = gen_mode(mode);
  assign prbs_on = (gmode != GEN_FIXED);
  assign mask_w  = LFSR_W'(poly_mask(gmode));
  assign seed_m  = seed & mask_w;
  assign seed_ld = (seed_m == '0) ? mask_w : seed_m;
  assign inv_w   = {16{invert}};

  tx_lfsr_step16 #(
    .LFSR_W (LFSR_W)
  ) u_step (
    .state_i (lfsr_q),
    .mode_i  (gmode),
    .state_o (step_state),
    .word_o  (step_word)
  );

`ifdef TX_DATA_GEN_ERR_INJ_EN
  logic [7:0] ecnt_q, ecnt_d;
  assign err_cnt = ecnt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    dout_d  = '0;
    valid_d = 1'b0;
`ifdef TX_DATA_GEN_ERR_INJ_EN
    ecnt_d  = ecnt_q;
`endif
    unique case (1'b1)
      (state_q == ST_PRE): begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          dout_d  = pre_pat ^ inv_w;
          valid_d = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - PRE_W'(1);
          if (cnt_q <= PRE_W'(1)) state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          dout_d  = (prbs_on ? step_word : fixed_pat) ^ inv_w;
          valid_d = 1'b1;
          if (prbs_on) lfsr_d = step_state;
`ifdef TX_DATA_GEN_ERR_INJ_EN
          if (err_inj) begin
            dout_d = dout_d ^ (16'd1 << err_pos);
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (en) begin
          cnt_d   = pre_len;
          state_d = (pre_len != '0) ? ST_PRE : ST_RUN;
        end
      end
    endcase
    // a seed load overrides any step this cycle
    if (load_seed) lfsr_d = seed_ld;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= '1;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

`ifdef TX_DATA_GEN_ERR_INJ_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) ecnt_q <= '0;
    else       ecnt_q <= ecnt_d;
  end
`endif

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  // readback shows the state as seen by the selected polynomial
  assign lfsr_state = lfsr_q & mask_w;

endmodule

// File: tb/tb_tx_data_gen.sv
// Randomised bench for tx_data_gen against a serial PRBS reference model.
// Error-injection checks are built when TX_DATA_GEN_ERR_INJ_EN is defined.
module tb_tx_data_gen;

  logic        clk;
  logic        rstb;
  logic        en;
  logic [2:0]  mode;
  logic [31:0] seed;
  logic        load_seed;
  logic [15:0] fixed_pat;
  logic [15:0] pre_pat;
  logic [7:0]  pre_len;
  logic        invert;
  logic [15:0] dout;
  logic        dout_valid;
  logic [31:0] lfsr_state;
`ifdef TX_DATA_GEN_ERR_INJ_EN
  logic        err_inj;
  logic [3:0]  err_pos;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  tx_data_gen #(
    .PRE_W  (8),
    .LFSR_W (32)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .mode       (mode),
    .seed       (seed),
    .load_seed  (load_seed),
    .fixed_pat  (fixed_pat),
    .pre_pat    (pre_pat),
    .pre_len    (pre_len),
    .invert     (invert),
`ifdef TX_DATA_GEN_ERR_INJ_EN
    .err_inj    (err_inj),
    .err_pos    (err_pos),
    .err_cnt    (err_cnt),
`endif
    .dout       (dout),
    .dout_valid (dout_valid),
    .lfsr_state (lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // polynomial taps indexed by mode: FIXED, PRBS7, PRBS9, PRBS15, PRBS31
  int unsigned PL [5] = '{0, 7, 9, 15, 31};
  int unsigned QL [5] = '{0, 6, 5, 14, 28};

  bit          m_on;
  int          m_left;
  logic [31:0] m_lfsr;
  logic [15:0] e_dout;
  logic [15:0] e_clean;
  logic        e_valid;
  int          e_cnt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mode_idx(logic [2:0] m);
    return (m >= 3'd5) ? 0 : int'(m);
  endfunction

  function automatic logic [31:0] mmask(int i);
    return (i == 0) ? 32'hFFFF_FFFF : (32'h1 << PL[i]) - 32'h1;
  endfunction

  task automatic model_reset();
    m_on    = 1'b0;
    m_left  = 0;
    m_lfsr  = 32'hFFFF_FFFF;
    e_dout  = '0;
    e_clean = '0;
    e_valid = 1'b0;
    e_cnt   = 0;
  endtask

  // advance the reference by one word using the inputs seen at this edge
  task automatic model_edge();
    int          mi;
    logic [31:0] msk, s, nb;
    logic [15:0] w;
    mi  = mode_idx(mode);
    msk = mmask(mi);
    w   = '0;
    if (!en) begin
      m_on = 1'b0; e_dout = '0; e_valid = 1'b0;
    end else if (!m_on) begin
      m_on = 1'b1; m_left = int'(pre_len); e_dout = '0; e_valid = 1'b0;
    end else if (m_left > 0) begin
      e_dout = pre_pat ^ {16{invert}}; e_valid = 1'b1; m_left--;
    end else begin
      if (mi != 0) begin
        s = m_lfsr & msk;
        if (s == 0) s = msk;
        for (int k = 0; k < 16; k++) begin
          nb   = ((s >> (PL[mi] - 1)) ^ (s >> (QL[mi] - 1))) & 32'd1;
          w[k] = nb[0];
          s    = ((s << 1) | nb) & msk;
        end
        m_lfsr = s;
      end else begin
        w = fixed_pat;
      end
      e_dout  = w ^ {16{invert}};
      e_clean = e_dout;
      e_valid = 1'b1;
`ifdef TX_DATA_GEN_ERR_INJ_EN
      if (err_inj) begin
        e_dout[err_pos] = ~e_dout[err_pos];
        if (e_cnt != 255) e_cnt++;
      end
`endif
    end
    if (load_seed) begin
      s = seed & msk;
      m_lfsr = (s == 0) ? msk : s;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("dout", 64'(dout), 64'(e_dout));
    chk("valid", 64'(dout_valid), 64'(e_valid));
    chk("lfsr", 64'(lfsr_state), 64'(m_lfsr & mmask(mode_idx(mode))));
`ifdef TX_DATA_GEN_ERR_INJ_EN
    chk("errcnt", 64'(err_cnt), 64'(e_cnt));
`endif
  endtask

  int n_pre;

  initial begin
    rstb = 1'b0; en = 1'b0; mode = 3'd1; seed = '0; load_seed = 1'b0;
    fixed_pat = '0; pre_pat = '0; pre_len = '0; invert = 1'b0;
`ifdef TX_DATA_GEN_ERR_INJ_EN
    err_inj = 1'b0; err_pos = '0;
`endif
    model_reset();
    #12;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_valid", 64'(dout_valid), 64'h0);
    chk("rst_lfsr", 64'(lfsr_state), 64'h7F);
    rstb = 1'b1;

    // PRBS7 from the reset state, no preamble
    en = 1'b1;
    tick();
    tick();
    chk("p7_word", 64'(dout), 64'h3040);
    chk("p7_state", 64'(lfsr_state), 64'h0C);
    chk("p7_valid", 64'(dout_valid), 64'h1);

    // preamble then fixed word, then inverted
    en = 1'b0;
    tick();
    mode = 3'd0; fixed_pat = 16'hA5A5; pre_pat = 16'hFF00; pre_len = 8'd3;
    en = 1'b1;
    tick();
    n_pre = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dout == 16'hFF00 && dout_valid) n_pre++;
    end
    chk("pre_cnt", 64'(n_pre), 64'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fixed", 64'(dout), 64'hA5A5);
    end
    invert = 1'b1;
    tick();
    chk("fixed_inv", 64'(dout), 64'h5A5A);

    // PRBS31 seeded with zero
    en = 1'b0; invert = 1'b0; pre_len = '0;
    tick();
    mode = 3'd4; seed = '0; load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    chk("seed0", 64'(lfsr_state), 64'h7FFF_FFFF);
    en = 1'b1;
    tick();
    for (int i = 0; i < 4096; i++) begin
      tick();
      chk("p31_nz", 64'(lfsr_state != 0), 64'd1);
    end

    // PRBS15 with a 5-cycle enable gap
    mode = 3'd3;
    repeat (20) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_dout", 64'(dout), 64'h0);
      chk("gap_valid", 64'(dout_valid), 64'h0);
    end
    en = 1'b1;
    repeat (30) tick();

    // asynchronous reset in the middle of a preamble
    en = 1'b0;
    tick();
    pre_len = 8'd4; pre_pat = 16'h1234; en = 1'b1;
    tick();
    tick();
    chk("pre_word", 64'(dout), 64'h1234);
    #2 rstb = 1'b0;
    #1;
    model_reset();
    chk("arst_dout", 64'(dout), 64'h0);
    chk("arst_valid", 64'(dout_valid), 64'h0);
    #1 rstb = 1'b1;
    repeat (8) tick();

`ifdef TX_DATA_GEN_ERR_INJ_EN
    en = 1'b0;
    tick();
    mode = 3'd2; pre_len = '0; en = 1'b1;
    repeat (4) tick();
    err_pos = 4'd9; err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    chk("err_bit", 64'(dout ^ e_clean), 64'h0200);
    tick();
    chk("err_next", 64'(dout), 64'(e_clean));
    chk("err_one", 64'(err_cnt), 64'd1);
`endif

    // randomised traffic across all modes
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      load_seed = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) invert = ~invert;
      pre_len   = 8'($urandom_range(0, 3));
      pre_pat   = 16'($urandom);
      fixed_pat = 16'($urandom);
`ifdef TX_DATA_GEN_ERR_INJ_EN
      err_inj = ($urandom_range(0, 9) == 0);
      err_pos = 4'($urandom_range(0, 15));
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_data_gen.md
Name: tx_data_gen

Overview:
- Word-parallel pattern source for the 16:1 transmitter.
- Runs on the prbs clock the Tx derives (full rate / 16) and drives the Tx 16-bit data input directly.
- Emits an optional fixed preamble, then a PRBS7/9/15/31 stream or a fixed word, 16 bits per cycle.
- Bit order: dout[0] is the first bit on the wire and dout[15] the last.

Parameters:
- PRE_W, 8, width of the preamble word-count field.
- LFSR_W, 32, LFSR register width; holds the longest polynomial (PRBS31).

Ports:
- clk  input  1  word clock (Tx prbs clock).
- rstb  input  1  asynchronous active-low reset.
- en  input  1  run enable; level-sensitive.
- mode  input  3  0=FIXED, 1=PRBS7, 2=PRBS9, 3=PRBS15, 4=PRBS31; 5-7 treated as FIXED.
- seed  input  LFSR_W  LFSR seed.
- load_seed  input  1  one-cycle pulse; loads the seed.
- fixed_pat  input  16  word for FIXED mode.
- pre_pat  input  16  preamble word.
- pre_len  input  PRE_W  number of preamble words; 0 = no preamble.
- invert  input  1  invert dout (polarity swap).
- dout  output  16  data word to the Tx.
- dout_valid  output  1  high while in PRE or RUN.
- lfsr_state  output  LFSR_W  current LFSR state, for debug readback.

Behaviour:
- Reset (rstb low, asynchronous):
  - dout=0, dout_valid=0, state=IDLE, pre counter=0.
  - LFSR=all-ones, masked to the current polynomial width.
- FSM states: IDLE, PRE, RUN.
  - IDLE: dout=0. When en=1, go to PRE if pre_len!=0, else go to RUN. Load the pre counter with pre_len.
  - PRE: dout=pre_pat. The counter decrements each cycle; exactly pre_len words are emitted, then go to RUN.
  - RUN: dout = PRBS word or fixed_pat, every cycle, while en=1.
  - en low in PRE or RUN: return to IDLE on the next edge. The LFSR holds its state; the preamble replays on re-enable.
- All outputs are registered; latency is 1 cycle.
  - en rising at edge N puts the first PRE or RUN word on dout after edge N+1.
  - dout_valid is asserted from that same edge.
- Polynomials (taps p, q, one-based): PRBS7 (7,6), PRBS9 (9,5), PRBS15 (15,14), PRBS31 (31,28).
- Serial step:
  - new = s[p-1] ^ s[q-1]
  - s = {s[LFSR_W-2:0], new}, masked to p bits
  - output bit = new
- 16 serial steps per clk in RUN; step k produces dout[k].
- LFSR advances only in RUN with a PRBS mode. It is frozen in IDLE, PRE and FIXED.
- invert=1 XORs dout with 16'hFFFF in PRE and RUN. It has no effect in IDLE (dout stays 0).
- load_seed:
  - Loads seed masked to p bits; takes priority over stepping in that cycle.
  - dout in that cycle still uses the pre-load state.
  - A masked seed of zero loads all-ones (lock-up protection).
- mode change while in RUN:
  - LFSR is re-masked to the new width on the next edge.
  - A state that becomes zero after masking is forced to all-ones.
  - No return to IDLE.
- The pre counter saturates at 0; pre_len changes mid-PRE are ignored until the next IDLE exit.

Optional Feature:
- Macro: TX_DATA_GEN_ERR_INJ_EN.
- With the macro defined:
  - Extra ports err_inj (1, one-cycle pulse) and err_pos (4).
  - In RUN, an err_inj pulse flips dout[err_pos] in the word registered at that edge. The LFSR is unaffected.
  - An 8-bit saturating err_cnt output counts injections.
  - err_inj is ignored outside RUN.
- Without the macro: no extra ports, no error logic.

Decomposition:
- const_pack additions:
  - tx_gen_mode_t enum: FIXED, PRBS7, PRBS9, PRBS15, PRBS31.
  - Tap and width constants per polynomial.
- One sub-module: tx_lfsr_step16.
  - Purely combinational 16-step unroll.
  - Inputs: state and mode. Outputs: next state and 16-bit word.
  - Also applies the zero-masking fix.

Test Plan:
- Reset, then mode=PRBS7, default seed 0x7F, pre_len=0, en=1 -> first RUN word dout=16'h3040; lfsr_state=7'h0C after it; dout_valid=1 from the same edge.
- pre_len=3, pre_pat=16'hFF00, mode=FIXED, fixed_pat=16'hA5A5 -> exactly 3 words of 16'hFF00, then 16'hA5A5 continuously; invert=1 gives 16'h5A5A.
- PRBS31 with seed=0 via load_seed -> state becomes all-ones, never zero; compare 2^12 words to a serial reference model with dout[0] first.
- PRBS15 mid-run en low for 5 cycles, then high -> dout=0 and dout_valid=0 while low; the stream resumes from the frozen state with no skipped bits.
- Assert rstb low asynchronously mid-word in PRE -> dout=0 and dout_valid=0 immediately without a clock edge; after release the FSM restarts from IDLE.
- With TX_DATA_GEN_ERR_INJ_EN: err_inj with err_pos=9 in PRBS9 -> exactly bit 9 differs from the reference, next word is clean, err_cnt=1.
